// File: rtl/fetch_hazard_ctrl.sv
// Fetch-stage sequencing controller: resolves EX branches, ID jumps, load-use
// hazards and multi-cycle EX occupancy into fetch stall/flush/redirect controls.
module fetch_hazard_ctrl #(
  parameter int unsigned REG_AW       = 5,
  parameter int unsigned MC_LAT       = 4,
  parameter int unsigned FLUSH_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic              id_jump,
  input  logic [31:0]       id_jump_target,
  input  logic              id_multicycle,
  input  logic              ex_load,
  input  logic              ex_wr,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_branch_taken,
  input  logic [31:0]       ex_branch_target,
  output logic              PC_stall,
  output logic              PC2_stall,
  output logic [1:0]        stall_flush_IR2,
  output logic              jump,
  output logic [31:0]       jump_address,
  output logic              ex_bubble,
  output logic              ex_hold,
  output logic              busy
);

  localparam logic [1:0] IR2Pass  = 2'b00;
  localparam logic [1:0] IR2Flush = 2'b01;
  localparam logic [1:0] IR2Hold  = 2'b10;

  typedef enum logic [1:0] {StRun, StFlush, StMcWait} state_e;

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       load_use;

  // Register 0 is hardwired, so a load targeting it never creates a dependency.
  assign load_use = ex_load & ex_wr & (ex_rd != '0) &
                    ((id_use_rs & (id_rs == ex_rd)) | (id_use_rt & (id_rt == ex_rd)));

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    PC_stall        = 1'b0;
    PC2_stall       = 1'b0;
    stall_flush_IR2 = IR2Pass;
    jump            = 1'b0;
    jump_address    = 32'h0;
    ex_bubble       = 1'b0;
    ex_hold         = 1'b0;
    busy            = 1'b0;

    if (!rst_n) begin
      stall_flush_IR2 = IR2Flush;
      ex_bubble       = 1'b1;
      state_d         = StRun;
      cnt_d           = 4'd0;
    end else begin
      busy = (state_q != StRun);
      case (state_q)
        StRun: begin
          if (ex_branch_taken) begin
            jump            = 1'b1;
            jump_address    = ex_branch_target;
            stall_flush_IR2 = IR2Flush;
            ex_bubble       = 1'b1;
            if (FLUSH_CYCLES > 0) begin
              state_d = StFlush;
              cnt_d   = 4'(FLUSH_CYCLES);
            end
          end else if (id_jump) begin
            jump            = 1'b1;
            jump_address    = id_jump_target;
            stall_flush_IR2 = IR2Flush;
          end else if (load_use) begin
            PC_stall        = 1'b1;
            PC2_stall       = 1'b1;
            stall_flush_IR2 = IR2Hold;
            ex_bubble       = 1'b1;
          end else if (id_multicycle && (MC_LAT > 1)) begin
            state_d = StMcWait;
            cnt_d   = 4'(MC_LAT - 1);
          end
        end
        StFlush: begin
          stall_flush_IR2 = IR2Flush;
          ex_bubble       = 1'b1;
          cnt_d           = cnt_q - 4'd1;
          if (cnt_q <= 4'd1) state_d = StRun;
        end
        StMcWait: begin
          PC_stall        = 1'b1;
          PC2_stall       = 1'b1;
          stall_flush_IR2 = IR2Hold;
          ex_hold         = 1'b1;
          cnt_d           = cnt_q - 4'd1;
          if (cnt_q <= 4'd1) state_d = StRun;
        end
        default: begin
          state_d = StRun;
          cnt_d   = 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StRun;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_fetch_hazard_ctrl.sv
// Bench for fetch_hazard_ctrl: directed scenarios then random traffic, every
// cycle compared against a cycle-count reference model.
module tb_fetch_hazard_ctrl;

  localparam int unsigned REG_AW       = 5;
  localparam int unsigned MC_LAT       = 4;
  localparam int unsigned FLUSH_CYCLES = 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [REG_AW-1:0] id_rs, id_rt, ex_rd;
  logic              id_use_rs, id_use_rt, id_jump, id_multicycle;
  logic              ex_load, ex_wr, ex_branch_taken;
  logic [31:0]       id_jump_target, ex_branch_target;
  logic              PC_stall, PC2_stall, jump, ex_bubble, ex_hold, busy;
  logic [1:0]        stall_flush_IR2;
  logic [31:0]       jump_address;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: remaining flush cycles and remaining multi-cycle wait cycles.
  int flush_left = 0;
  int wait_left  = 0;

  always #5 clk = ~clk;

  fetch_hazard_ctrl #(
    .REG_AW      (REG_AW),
    .MC_LAT      (MC_LAT),
    .FLUSH_CYCLES(FLUSH_CYCLES)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_use_rs       (id_use_rs),
    .id_use_rt       (id_use_rt),
    .id_jump         (id_jump),
    .id_jump_target  (id_jump_target),
    .id_multicycle   (id_multicycle),
    .ex_load         (ex_load),
    .ex_wr           (ex_wr),
    .ex_rd           (ex_rd),
    .ex_branch_taken (ex_branch_taken),
    .ex_branch_target(ex_branch_target),
    .PC_stall        (PC_stall),
    .PC2_stall       (PC2_stall),
    .stall_flush_IR2 (stall_flush_IR2),
    .jump            (jump),
    .jump_address    (jump_address),
    .ex_bubble       (ex_bubble),
    .ex_hold         (ex_hold),
    .busy            (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s @%0t: got %0h, expected %0h", tag, $time, obs, exp);
  endtask

  task automatic clear_inputs();
    rst_n            = 1'b1;
    id_rs            = '0;
    id_rt            = '0;
    ex_rd            = '0;
    id_use_rs        = 1'b0;
    id_use_rt        = 1'b0;
    id_jump          = 1'b0;
    id_multicycle    = 1'b0;
    ex_load          = 1'b0;
    ex_wr            = 1'b0;
    ex_branch_taken  = 1'b0;
    id_jump_target   = 32'h0;
    ex_branch_target = 32'h0;
  endtask

  // Check one cycle of outputs against the model, then advance both across a posedge.
  task automatic cycle();
    logic        e_pcs, e_pc2s, e_jump, e_bub, e_hold, e_busy, hazard;
    logic [1:0]  e_sf;
    logic [31:0] e_addr;
    int          nf, nw;
    e_pcs = 0; e_pc2s = 0; e_jump = 0; e_bub = 0; e_hold = 0; e_busy = 0;
    e_sf = 2'b00; e_addr = 32'h0;
    nf = flush_left; nw = wait_left;
    hazard = ex_load && ex_wr && (ex_rd != 0) &&
             ((id_use_rs && id_rs == ex_rd) || (id_use_rt && id_rt == ex_rd));
    #1;
    if (!rst_n) begin
      e_sf = 2'b01; e_bub = 1; nf = 0; nw = 0;
    end else if (flush_left > 0) begin
      e_busy = 1; e_sf = 2'b01; e_bub = 1; nf = flush_left - 1;
    end else if (wait_left > 0) begin
      e_busy = 1; e_pcs = 1; e_pc2s = 1; e_sf = 2'b10; e_hold = 1; nw = wait_left - 1;
    end else if (ex_branch_taken) begin
      e_jump = 1; e_addr = ex_branch_target; e_sf = 2'b01; e_bub = 1; nf = FLUSH_CYCLES;
    end else if (id_jump) begin
      e_jump = 1; e_addr = id_jump_target; e_sf = 2'b01;
    end else if (hazard) begin
      e_pcs = 1; e_pc2s = 1; e_sf = 2'b10; e_bub = 1;
    end else if (id_multicycle) begin
      nw = MC_LAT - 1;
    end
    check("PC_stall",        32'(PC_stall),        32'(e_pcs));
    check("PC2_stall",       32'(PC2_stall),       32'(e_pc2s));
    check("stall_flush_IR2", 32'(stall_flush_IR2), 32'(e_sf));
    check("jump",            32'(jump),            32'(e_jump));
    check("jump_address",    jump_address,         e_addr);
    check("ex_bubble",       32'(ex_bubble),       32'(e_bub));
    check("ex_hold",         32'(ex_hold),         32'(e_hold));
    check("busy",            32'(busy),            32'(e_busy));
    @(posedge clk);
    flush_left = nf;
    wait_left  = nw;
    #1;
  endtask

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    #2;
    cycle(); cycle();
    rst_n = 1'b1;
    cycle();

    // Taken branch: one redirect cycle, one extra flush cycle.
    ex_branch_taken = 1; ex_branch_target = 32'h14;
    cycle();
    clear_inputs();
    cycle(); cycle();

    // Load-use on r3, then the same pattern on r0.
    ex_load = 1; ex_wr = 1; ex_rd = 3; id_rs = 3; id_use_rs = 1;
    cycle();
    clear_inputs();
    cycle();
    ex_load = 1; ex_wr = 1; ex_rd = 0; id_rs = 0; id_use_rs = 1;
    cycle();
    clear_inputs();

    // Multi-cycle op, branch presented during the wait.
    id_multicycle = 1;
    cycle();
    clear_inputs();
    ex_branch_taken = 1; ex_branch_target = 32'hdead_0000;
    cycle(); cycle();
    clear_inputs();
    cycle(); cycle();

    // Branch + jump + load-use together.
    ex_branch_taken = 1; ex_branch_target = 32'h0000_0100;
    id_jump = 1; id_jump_target = 32'h0000_0200;
    ex_load = 1; ex_wr = 1; ex_rd = 5; id_rt = 5; id_use_rt = 1;
    cycle();
    clear_inputs();
    cycle(); cycle();

    // Reset after one wait cycle of a multi-cycle op.
    id_multicycle = 1;
    cycle();
    clear_inputs();
    cycle();
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    cycle(); cycle();

    for (int i = 0; i < 3000; i++) begin
      rst_n            = ($urandom_range(99) >= 2);
      id_rs            = REG_AW'($urandom_range(3));
      id_rt            = REG_AW'($urandom_range(3));
      ex_rd            = REG_AW'($urandom_range(3));
      id_use_rs        = 1'($urandom_range(1));
      id_use_rt        = 1'($urandom_range(1));
      ex_load          = 1'($urandom_range(1));
      ex_wr            = 1'($urandom_range(1));
      id_jump          = ($urandom_range(9) == 0);
      id_multicycle    = ($urandom_range(7) == 0);
      ex_branch_taken  = ($urandom_range(9) == 0);
      id_jump_target   = $urandom;
      ex_branch_target = $urandom;
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
